// File: rtl/ddr_test_sequencer.sv
// DDR throughput test sequencer: drives a pattern into the DDR output stage,
// checks the looped-back beats against an independent copy, and reports the result.
module ddr_test_sequencer #(
  parameter int LEN_W   = 16,
  parameter int TMO_CYC = 255
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic             abort,
  input  logic [LEN_W-1:0] cfg_len,
  input  logic [1:0]       cfg_mode,
  input  logic             tx_ready,
  output logic             tx_valid,
  output logic [7:0]       tx_rise,
  output logic [7:0]       tx_fall,
  input  logic             rx_valid,
  input  logic [7:0]       rx_rise,
  input  logic [7:0]       rx_fall,
  output logic             busy,
  output logic             done,
  output logic             pass,
  output logic             timeout,
  output logic [LEN_W-1:0] tx_count,
  output logic [LEN_W-1:0] rx_count,
  output logic [15:0]      err_count
);

  typedef enum logic [1:0] {IDLE, RUN, DRAIN, DONE} state_t;
  localparam int TMO_W = $clog2(TMO_CYC + 1);

  state_t           state, next_state;
  logic [LEN_W-1:0] len;
  logic [1:0]       mode;
  logic [7:0]       tx_gen, rx_gen;
  logic [TMO_W-1:0] tmo_cnt;
  logic [7:0]       seed, seed_fall, seed_next, tx_gen_fall, rx_gen_fall;
  logic             start_ok, tx_accept, tx_last, rx_take, rx_bad, tmo_hit, drain_exit;

  // One step of the pattern stream; every mode is expressible as p(n+1) = f(p(n)).
  function automatic logic [7:0] pat_step(input logic [1:0] m, input logic [7:0] v);
    case (m)
      2'd0:    pat_step = v + 8'd1;
      2'd1:    pat_step = {v[6:0], v[7] ^ v[5] ^ v[4] ^ v[3]};
      2'd2:    pat_step = {v[6:0], v[7]};
      default: pat_step = ~v;
    endcase
  endfunction

  always_comb begin
    seed = 8'h01;
    if (cfg_mode == 2'd0) seed = 8'h00;
    else if (cfg_mode == 2'd3) seed = 8'h55;
  end

  assign seed_fall   = pat_step(cfg_mode, seed);
  assign seed_next   = pat_step(cfg_mode, seed_fall);
  assign tx_gen_fall = pat_step(mode, tx_gen);
  assign rx_gen_fall = pat_step(mode, rx_gen);

  assign start_ok  = start && !abort && (state == IDLE || state == DONE);
  assign tx_accept = (state == RUN) && tx_valid && tx_ready;
  assign tx_last   = tx_accept && (tx_count + LEN_W'(1) == len);
  assign rx_take   = (state == RUN || state == DRAIN) && rx_valid && (rx_count != len);
  assign rx_bad    = (rx_rise != rx_gen) || (rx_fall != rx_gen_fall);
  assign tmo_hit   = (state == DRAIN) && !rx_valid && (tmo_cnt == TMO_W'(TMO_CYC - 1));

  always_comb begin
    next_state = state;
    if (abort) begin
      next_state = IDLE;
    end else begin
      case (state)
        IDLE, DONE: if (start) next_state = (cfg_len == '0) ? DONE : RUN;
        RUN:        if (tx_last) next_state = DRAIN;
        DRAIN:      if (rx_count == len || tmo_hit) next_state = DONE;
        default:    next_state = IDLE;
      endcase
    end
  end

  assign drain_exit = (state == DRAIN) && (next_state == DONE);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) state <= IDLE;
    else     state <= next_state;
  end

  // Registered outputs, counters and the two pattern generators.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      tx_valid  <= 1'b0;
      tx_rise   <= '0;
      tx_fall   <= '0;
      busy      <= 1'b0;
      done      <= 1'b0;
      pass      <= 1'b0;
      timeout   <= 1'b0;
      tx_count  <= '0;
      rx_count  <= '0;
      err_count <= '0;
      len       <= '0;
      mode      <= '0;
      tx_gen    <= '0;
      rx_gen    <= '0;
      tmo_cnt   <= '0;
    end else if (abort) begin
      tx_valid <= 1'b0;
      tx_rise  <= '0;
      tx_fall  <= '0;
      busy     <= 1'b0;
      done     <= 1'b0;
      pass     <= 1'b0;
      timeout  <= 1'b0;
      tmo_cnt  <= '0;
    end else if (start_ok) begin
      len       <= cfg_len;
      mode      <= cfg_mode;
      tx_count  <= '0;
      rx_count  <= '0;
      err_count <= '0;
      timeout   <= 1'b0;
      tmo_cnt   <= '0;
      rx_gen    <= seed;
      tx_gen    <= seed_next;
      if (cfg_len != '0) begin
        tx_valid <= 1'b1;
        tx_rise  <= seed;
        tx_fall  <= seed_fall;
        busy     <= 1'b1;
        done     <= 1'b0;
        pass     <= 1'b0;
      end else begin
        tx_valid <= 1'b0;
        tx_rise  <= '0;
        tx_fall  <= '0;
        busy     <= 1'b0;
        done     <= 1'b1;
        pass     <= 1'b1;
      end
    end else begin
      if (tx_accept) begin
        tx_count <= tx_count + LEN_W'(1);
        if (tx_last) begin
          tx_valid <= 1'b0;
          tx_rise  <= '0;
          tx_fall  <= '0;
        end else begin
          tx_rise <= tx_gen;
          tx_fall <= tx_gen_fall;
          tx_gen  <= pat_step(mode, tx_gen_fall);
        end
      end
      if (rx_take) begin
        rx_count <= rx_count + LEN_W'(1);
        rx_gen   <= pat_step(mode, rx_gen_fall);
        if (rx_bad && err_count != 16'hFFFF) err_count <= err_count + 16'd1;
      end
      if (state == DRAIN) tmo_cnt <= rx_valid ? '0 : tmo_cnt + TMO_W'(1);
      else                tmo_cnt <= '0;
      if (drain_exit) begin
        busy    <= 1'b0;
        done    <= 1'b1;
        pass    <= (err_count == 16'd0) && (rx_count == len);
        timeout <= (rx_count != len);
      end
    end
  end

endmodule

// File: tb/tb_ddr_test_sequencer.sv
// Self-checking bench for ddr_test_sequencer: loopback model, pattern reference
// computed from the pattern definitions, directed and randomized runs.
module tb_ddr_test_sequencer;

  localparam int LEN_W = 16;
  localparam int TMO   = 255;

  logic             clk = 1'b0, rst = 1'b1, start = 1'b0, abort = 1'b0;
  logic [LEN_W-1:0] cfg_len = '0;
  logic [1:0]       cfg_mode = '0;
  logic             tx_ready = 1'b0, rx_valid = 1'b0;
  logic [7:0]       rx_rise = '0, rx_fall = '0;
  logic             tx_valid, busy, done, pass, timeout;
  logic [7:0]       tx_rise, tx_fall;
  logic [LEN_W-1:0] tx_count, rx_count;
  logic [15:0]      err_count;

  ddr_test_sequencer #(.LEN_W(LEN_W), .TMO_CYC(TMO)) dut (
    .clk(clk), .rst(rst), .start(start), .abort(abort),
    .cfg_len(cfg_len), .cfg_mode(cfg_mode), .tx_ready(tx_ready),
    .tx_valid(tx_valid), .tx_rise(tx_rise), .tx_fall(tx_fall),
    .rx_valid(rx_valid), .rx_rise(rx_rise), .rx_fall(rx_fall),
    .busy(busy), .done(done), .pass(pass), .timeout(timeout),
    .tx_count(tx_count), .rx_count(rx_count), .err_count(err_count)
  );

  always #5 clk = ~clk;

  typedef struct {int due; logic [7:0] r; logic [7:0] f;} lb_t;

  int         checks = 0, fails = 0;
  int         cyc = 0, rdy_mode = 0, lb_delay = 2, drop_from = 1000;
  int         last_rx_cyc = -1, rx_sent = 0, bad_sent = 0, stall_viol = 0;
  logic [7:0] flip_r[64], flip_f[64];
  lb_t        pipe[$];
  logic [7:0] acc_r[$], acc_f[$];
  logic       prev_stall = 1'b0;
  logic [7:0] prev_r = '0, prev_f = '0;

  // Pattern byte n of a mode, straight from the stream definitions.
  function automatic logic [7:0] pat(input int m, input int n);
    logic [7:0] v;
    v = 8'h01;
    case (m)
      0: v = n[7:0];
      1: for (int i = 0; i < n; i++) v = {v[6:0], v[7] ^ v[5] ^ v[4] ^ v[3]};
      2: v = 8'(1 << (n % 8));
      default: v = (n % 2 == 1) ? 8'hAA : 8'h55;
    endcase
    return v;
  endfunction

  task automatic setup(input int m, input int len, input int rmode, input int delay, input int drop);
    pipe.delete(); acc_r.delete(); acc_f.delete();
    for (int i = 0; i < 64; i++) begin flip_r[i] = '0; flip_f[i] = '0; end
    cfg_mode = 2'(m); cfg_len = LEN_W'(len); rdy_mode = rmode; lb_delay = delay; drop_from = drop;
    last_rx_cyc = -1; rx_sent = 0; bad_sent = 0; stall_viol = 0; prev_stall = 1'b0;
    start = 1'b0; abort = 1'b0;
  endtask

  // One clock: loopback delivery, tx_ready choice, scoreboard capture; returns at negedge.
  task automatic tick();
    lb_t b;
    int  idx;
    rx_valid = 1'b0; rx_rise = 8'($urandom); rx_fall = 8'($urandom);
    if (pipe.size() > 0 && pipe[0].due <= cyc) begin
      b = pipe.pop_front();
      rx_valid = 1'b1; rx_rise = b.r; rx_fall = b.f;
      last_rx_cyc = cyc; rx_sent++;
    end
    if (prev_stall && tx_valid && (tx_rise !== prev_r || tx_fall !== prev_f)) stall_viol++;
    case (rdy_mode)
      0: tx_ready = 1'b1;
      1: tx_ready = (cyc % 2 == 0);
      default: tx_ready = 1'($urandom_range(0, 1));
    endcase
    if (tx_valid && tx_ready) begin
      idx = acc_r.size();
      acc_r.push_back(tx_rise); acc_f.push_back(tx_fall);
      if (idx < drop_from) begin
        b.due = cyc + lb_delay;
        b.r = tx_rise ^ ((idx < 64) ? flip_r[idx] : 8'h00);
        b.f = tx_fall ^ ((idx < 64) ? flip_f[idx] : 8'h00);
        if (idx < 64 && (flip_r[idx] != 0 || flip_f[idx] != 0)) bad_sent++;
        pipe.push_back(b);
      end
    end
    prev_stall = tx_valid && !tx_ready; prev_r = tx_rise; prev_f = tx_fall;
    @(posedge clk);
    @(negedge clk);
    cyc++;
  endtask

  task automatic pulse_start();
    start = 1'b1; tick(); start = 1'b0;
  endtask

  task automatic wait_done(input int budget, output int n);
    n = -1;
    for (int i = 0; i < budget; i++) begin
      if (done === 1'b1) begin n = i; return; end
      tick();
    end
    if (done === 1'b1) n = budget;
  endtask

  task automatic test_reset();
    @(negedge clk);
    checks++;
    if ({tx_valid, busy, done, pass, timeout} !== 5'b0) begin
      fails++; $display("[TB] FAIL reset_flags: got %b expected 00000", {tx_valid, busy, done, pass, timeout});
    end
    checks++;
    if ({tx_rise, tx_fall} !== 16'h0) begin
      fails++; $display("[TB] FAIL reset_bytes: got %h expected 0000", {tx_rise, tx_fall});
    end
    checks++;
    if ({tx_count, rx_count, err_count} !== 48'h0) begin
      fails++; $display("[TB] FAIL reset_counts: got %0d/%0d/%0d expected 0/0/0", tx_count, rx_count, err_count);
    end
    rst = 1'b0;
  endtask

  task automatic test_counter_mode();
    int n;
    setup(0, 4, 0, 2, 1000);
    pulse_start();
    checks++;
    if ({tx_valid, busy, tx_rise, tx_fall} !== {2'b11, 8'h00, 8'h01}) begin
      fails++; $display("[TB] FAIL first_beat: got v=%b b=%b %h/%h expected v=1 b=1 00/01", tx_valid, busy, tx_rise, tx_fall);
    end
    wait_done(100, n);
    checks++;
    if (n < 0) begin fails++; $display("[TB] FAIL cnt_done_wait: got no done expected done within 100"); end
    checks++;
    if (acc_r.size() != 4) begin fails++; $display("[TB] FAIL cnt_beats: got %0d expected 4", acc_r.size()); end
    for (int k = 0; k < acc_r.size() && k < 4; k++) begin
      checks++;
      if (acc_r[k] !== pat(0, 2*k) || acc_f[k] !== pat(0, 2*k+1)) begin
        fails++; $display("[TB] FAIL cnt_beat%0d: got %h/%h expected %h/%h", k, acc_r[k], acc_f[k], pat(0, 2*k), pat(0, 2*k+1));
      end
    end
    checks++;
    if ({pass, timeout, tx_count, rx_count, err_count} !== {2'b10, 16'd4, 16'd4, 16'd0}) begin
      fails++; $display("[TB] FAIL cnt_result: got p=%b t=%b %0d/%0d/%0d expected p=1 t=0 4/4/0", pass, timeout, tx_count, rx_count, err_count);
    end
    checks++;
    if ({tx_valid, busy, tx_rise, tx_fall} !== 18'h0) begin
      fails++; $display("[TB] FAIL cnt_done_outs: got v=%b b=%b %h/%h expected all zero", tx_valid, busy, tx_rise, tx_fall);
    end
  endtask

  task automatic test_lfsr_stall();
    int n;
    setup(1, 3, 1, 2, 1000);
    pulse_start();
    wait_done(100, n);
    checks++;
    if (n < 0) begin fails++; $display("[TB] FAIL lfsr_done_wait: got no done expected done within 100"); end
    checks++;
    if (acc_r.size() != 3) begin fails++; $display("[TB] FAIL lfsr_beats: got %0d expected 3", acc_r.size()); end
    for (int k = 0; k < acc_r.size() && k < 3; k++) begin
      checks++;
      if (acc_r[k] !== pat(1, 2*k) || acc_f[k] !== pat(1, 2*k+1)) begin
        fails++; $display("[TB] FAIL lfsr_beat%0d: got %h/%h expected %h/%h", k, acc_r[k], acc_f[k], pat(1, 2*k), pat(1, 2*k+1));
      end
    end
    checks++;
    if (stall_viol != 0) begin fails++; $display("[TB] FAIL lfsr_stall_hold: got %0d changes expected 0", stall_viol); end
    checks++;
    if ({pass, tx_count, rx_count, err_count} !== {1'b1, 16'd3, 16'd3, 16'd0}) begin
      fails++; $display("[TB] FAIL lfsr_result: got p=%b %0d/%0d/%0d expected p=1 3/3/0", pass, tx_count, rx_count, err_count);
    end
  endtask

  task automatic test_alt_errors();
    int n;
    setup(3, 8, 0, 2, 1000);
    flip_f[2] = 8'h01; flip_f[5] = 8'h01;
    pulse_start();
    wait_done(100, n);
    checks++;
    if (n < 0) begin fails++; $display("[TB] FAIL alt_done_wait: got no done expected done within 100"); end
    for (int k = 0; k < acc_r.size() && k < 8; k++) begin
      checks++;
      if (acc_r[k] !== pat(3, 2*k) || acc_f[k] !== pat(3, 2*k+1)) begin
        fails++; $display("[TB] FAIL alt_beat%0d: got %h/%h expected %h/%h", k, acc_r[k], acc_f[k], pat(3, 2*k), pat(3, 2*k+1));
      end
    end
    checks++;
    if ({pass, timeout, tx_count, rx_count, err_count} !== {2'b00, 16'd8, 16'd8, 16'd2}) begin
      fails++; $display("[TB] FAIL alt_result: got p=%b t=%b %0d/%0d/%0d expected p=0 t=0 8/8/2", pass, timeout, tx_count, rx_count, err_count);
    end
  endtask

  task automatic test_walk_timeout();
    int n;
    setup(2, 5, 0, 2, 4);
    pulse_start();
    wait_done(1000, n);
    checks++;
    if (n < 0) begin fails++; $display("[TB] FAIL tmo_done_wait: got no done expected done within 1000"); end
    checks++;
    if ((cyc - 1) - last_rx_cyc != TMO) begin
      fails++; $display("[TB] FAIL tmo_latency: got %0d cycles expected %0d", (cyc - 1) - last_rx_cyc, TMO);
    end
    for (int k = 0; k < acc_r.size() && k < 5; k++) begin
      checks++;
      if (acc_r[k] !== pat(2, 2*k) || acc_f[k] !== pat(2, 2*k+1)) begin
        fails++; $display("[TB] FAIL walk_beat%0d: got %h/%h expected %h/%h", k, acc_r[k], acc_f[k], pat(2, 2*k), pat(2, 2*k+1));
      end
    end
    checks++;
    if ({pass, timeout, tx_count, rx_count, err_count} !== {2'b01, 16'd5, 16'd4, 16'd0}) begin
      fails++; $display("[TB] FAIL tmo_result: got p=%b t=%b %0d/%0d/%0d expected p=0 t=1 5/4/0", pass, timeout, tx_count, rx_count, err_count);
    end
  endtask

  task automatic test_abort();
    int exp_tx, exp_rx;
    setup(0, 10, 0, 2, 1000);
    pulse_start();
    checks++;
    if (timeout !== 1'b0) begin fails++; $display("[TB] FAIL abort_tmo_clear: got %b expected 0", timeout); end
    repeat (3) tick();
    exp_tx = acc_r.size(); exp_rx = rx_sent;
    abort = 1'b1; start = 1'b1;
    tick();
    abort = 1'b0; start = 1'b0;
    checks++;
    if ({tx_valid, busy, done, pass} !== 4'b0) begin
      fails++; $display("[TB] FAIL abort_flags: got %b expected 0000", {tx_valid, busy, done, pass});
    end
    checks++;
    if (tx_count !== LEN_W'(exp_tx) || rx_count !== LEN_W'(exp_rx)) begin
      fails++; $display("[TB] FAIL abort_hold: got %0d/%0d expected %0d/%0d", tx_count, rx_count, exp_tx, exp_rx);
    end
    repeat (4) tick();
    checks++;
    if (done !== 1'b0 || tx_count !== LEN_W'(exp_tx) || rx_count !== LEN_W'(exp_rx)) begin
      fails++; $display("[TB] FAIL idle_ignore: got d=%b %0d/%0d expected d=0 %0d/%0d", done, tx_count, rx_count, exp_tx, exp_rx);
    end
    cfg_len = '0;
    pulse_start();
    checks++;
    if ({done, pass, busy, tx_valid, tx_count, rx_count} !== {4'b1100, 32'd0}) begin
      fails++; $display("[TB] FAIL zero_len: got d=%b p=%b b=%b v=%b %0d/%0d expected d=1 p=1 b=0 v=0 0/0", done, pass, busy, tx_valid, tx_count, rx_count);
    end
  endtask

  task automatic test_reset_in_drain();
    bit found;
    setup(0, 6, 0, 30, 1000);
    pulse_start();
    found = 1'b0;
    for (int i = 0; i < 60 && !found; i++) begin
      if (busy === 1'b1 && tx_valid === 1'b0) found = 1'b1;
      else tick();
    end
    checks++;
    if (!found) begin fails++; $display("[TB] FAIL drain_reach: got no drain expected drain within 60"); end
    rst = 1'b1;
    #1;
    checks++;
    if ({tx_valid, busy, done, pass, timeout, tx_rise, tx_fall} !== 21'h0) begin
      fails++; $display("[TB] FAIL rst_drain_outs: got %b %h/%h expected all zero", {tx_valid, busy, done, pass, timeout}, tx_rise, tx_fall);
    end
    checks++;
    if ({tx_count, rx_count, err_count} !== 48'h0) begin
      fails++; $display("[TB] FAIL rst_drain_counts: got %0d/%0d/%0d expected 0/0/0", tx_count, rx_count, err_count);
    end
    #2;
    rst = 1'b0;
    @(negedge clk);
  endtask

  task automatic test_random();
    int n, m, len;
    for (int r = 0; r < 6; r++) begin
      m = $urandom_range(0, 3);
      len = $urandom_range(1, 12);
      setup(m, len, 2, $urandom_range(1, 4), 1000);
      for (int k = 0; k < len; k++) begin
        if ($urandom_range(0, 3) == 0) begin
          if ($urandom_range(0, 1) == 1) flip_r[k] = 8'(1 << $urandom_range(0, 7));
          else                           flip_f[k] = 8'(1 << $urandom_range(0, 7));
        end
      end
      pulse_start();
      wait_done(400, n);
      checks++;
      if (n < 0) begin fails++; $display("[TB] FAIL rnd%0d_done_wait: got no done expected done within 400", r); end
      checks++;
      if (acc_r.size() != len) begin fails++; $display("[TB] FAIL rnd%0d_beats: got %0d expected %0d", r, acc_r.size(), len); end
      for (int k = 0; k < acc_r.size() && k < len; k++) begin
        checks++;
        if (acc_r[k] !== pat(m, 2*k) || acc_f[k] !== pat(m, 2*k+1)) begin
          fails++; $display("[TB] FAIL rnd%0d_beat%0d: got %h/%h expected %h/%h", r, k, acc_r[k], acc_f[k], pat(m, 2*k), pat(m, 2*k+1));
        end
      end
      checks++;
      if (tx_count !== LEN_W'(len) || rx_count !== LEN_W'(len) || err_count !== 16'(bad_sent) ||
          pass !== (bad_sent == 0) || timeout !== 1'b0) begin
        fails++; $display("[TB] FAIL rnd%0d_result: got p=%b t=%b %0d/%0d/%0d expected p=%b t=0 %0d/%0d/%0d",
                          r, pass, timeout, tx_count, rx_count, err_count, bad_sent == 0, len, len, bad_sent);
      end
    end
  endtask

  initial begin
    test_reset();
    test_counter_mode();
    test_lfsr_stall();
    test_alt_errors();
    test_walk_timeout();
    test_abort();
    test_reset_in_drain();
    test_random();
    $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
    $finish;
  end

endmodule
